// File: rtl/infix_to_onp.sv
// Shunting-yard converter: infix token stream in, ONP push/op command stream out.
// Latency: NUM appears on the output one cycle after acceptance; each operator pop takes one cycle.
// Backpressure: the output is a single registered slot; in_ready and stack pops stall while it is held.
module infix_to_onp #(
    parameter int DEPTH = 16,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_kind,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_push,
    output logic [15:0] out_d,
    output logic [1:0]  out_op,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] K_NUM  = 3'd0;
    localparam logic [2:0] K_ADD  = 3'd1;
    localparam logic [2:0] K_MUL  = 3'd2;
    localparam logic [2:0] K_NEG  = 3'd3;
    localparam logic [2:0] K_LPAR = 3'd4;
    localparam logic [2:0] K_RPAR = 3'd5;
    localparam logic [2:0] K_END  = 3'd6;

    // Stack entries reuse the calculator op encoding; 00 marks an LPAR.
    localparam logic [1:0] C_LPAR = 2'b00;
    localparam logic [1:0] C_NEG  = 2'b01;
    localparam logic [1:0] C_ADD  = 2'b10;
    localparam logic [1:0] C_MUL  = 2'b11;

    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_ACCEPT,
        S_POP_OP,
        S_POP_PAR,
        S_FLUSH,
        S_DONE,
        S_ERR
    } state_t;

    state_t state, nxt_state;

    logic [1:0]    stk [DEPTH];
    logic [PW:0]   sp;
    logic [PW-1:0] top_idx;
    logic [1:0]    top;
    logic          empty, full;

    logic          expect_opnd, nxt_expect;
    logic [1:0]    pend;

    logic          slot_free, accept, legal;
    logic          do_push, do_pop, emit_num, emit_op, latch_pend, set_err, done_nxt;
    logic [1:0]    push_code;

    function automatic logic [1:0] prec(input logic [1:0] c);
        case (c)
            C_NEG:   prec = 2'd3;
            C_MUL:   prec = 2'd2;
            C_ADD:   prec = 2'd1;
            default: prec = 2'd0;
        endcase
    endfunction

    assign top_idx   = sp[PW-1:0] - 1'b1;
    assign top       = stk[top_idx];
    assign empty     = (sp == '0);
    assign full      = (sp == FULL_CNT);
    assign slot_free = !out_valid || out_ready;
    assign in_ready  = (state == S_ACCEPT) && !err && slot_free;
    assign accept    = in_valid && in_ready;

    always_comb begin
        legal = 1'b0;
        if (expect_opnd)
            legal = (in_kind == K_NUM) || (in_kind == K_NEG) || (in_kind == K_LPAR);
        else
            legal = (in_kind == K_ADD) || (in_kind == K_MUL) ||
                    (in_kind == K_RPAR) || (in_kind == K_END);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_ACCEPT;
        else     state <= nxt_state;
    end

    always_comb begin
        nxt_state  = state;
        nxt_expect = expect_opnd;
        do_push    = 1'b0;
        push_code  = C_LPAR;
        do_pop     = 1'b0;
        emit_num   = 1'b0;
        emit_op    = 1'b0;
        latch_pend = 1'b0;
        set_err    = 1'b0;
        done_nxt   = 1'b0;
        case (state)
            S_ACCEPT: begin
                if (accept) begin
                    if (!legal) begin
                        set_err   = 1'b1;
                        nxt_state = S_ERR;
                    end else begin
                        case (in_kind)
                            K_NUM: begin
                                emit_num   = 1'b1;
                                nxt_expect = 1'b0;
                            end
                            K_NEG, K_LPAR: begin
                                if (full) begin
                                    set_err   = 1'b1;
                                    nxt_state = S_ERR;
                                end else begin
                                    do_push   = 1'b1;
                                    push_code = (in_kind == K_NEG) ? C_NEG : C_LPAR;
                                end
                            end
                            K_ADD, K_MUL: begin
                                latch_pend = 1'b1;
                                nxt_expect = 1'b1;
                                nxt_state  = S_POP_OP;
                            end
                            K_RPAR:  nxt_state = S_POP_PAR;
                            default: nxt_state = S_FLUSH;
                        endcase
                    end
                end
            end
            S_POP_OP: begin
                if (slot_free) begin
                    if (!empty && (prec(top) >= prec(pend))) begin
                        do_pop  = 1'b1;
                        emit_op = 1'b1;
                    end else if (full) begin
                        set_err   = 1'b1;
                        nxt_state = S_ERR;
                    end else begin
                        do_push   = 1'b1;
                        push_code = pend;
                        nxt_state = S_ACCEPT;
                    end
                end
            end
            S_POP_PAR: begin
                if (slot_free) begin
                    if (empty) begin
                        set_err   = 1'b1;
                        nxt_state = S_ERR;
                    end else if (top == C_LPAR) begin
                        do_pop     = 1'b1;
                        nxt_expect = 1'b0;
                        nxt_state  = S_ACCEPT;
                    end else begin
                        do_pop  = 1'b1;
                        emit_op = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                if (slot_free) begin
                    if (empty) begin
                        nxt_state = S_DONE;
                    end else if (top == C_LPAR) begin
                        set_err   = 1'b1;
                        nxt_state = S_ERR;
                    end else begin
                        do_pop  = 1'b1;
                        emit_op = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (!out_valid) begin
                    done_nxt   = 1'b1;
                    nxt_expect = 1'b1;
                    nxt_state  = S_ACCEPT;
                end
            end
            default: nxt_state = S_ERR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp          <= '0;
            expect_opnd <= 1'b1;
            pend        <= C_ADD;
            err         <= 1'b0;
            done        <= 1'b0;
        end else begin
            if (do_push)      sp <= sp + 1'b1;
            else if (do_pop)  sp <= sp - 1'b1;
            expect_opnd <= nxt_expect;
            if (latch_pend)   pend <= (in_kind == K_MUL) ? C_MUL : C_ADD;
            if (set_err)      err <= 1'b1;
            done <= done_nxt;
        end
    end

    // Stack storage needs no reset: sp alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) stk[sp[PW-1:0]] <= push_code;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_push  <= 1'b0;
            out_d     <= '0;
            out_op    <= '0;
        end else if (emit_num) begin
            out_valid <= 1'b1;
            out_push  <= 1'b1;
            out_d     <= in_data;
            out_op    <= '0;
        end else if (emit_op) begin
            out_valid <= 1'b1;
            out_push  <= 1'b0;
            out_d     <= '0;
            out_op    <= top;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_infix_to_onp.sv
// Bench for infix_to_onp: scoreboard of expected push/op tokens, stall and error scenarios.
module tb_infix_to_onp;

    localparam logic [2:0] K_NUM  = 3'd0;
    localparam logic [2:0] K_ADD  = 3'd1;
    localparam logic [2:0] K_MUL  = 3'd2;
    localparam logic [2:0] K_NEG  = 3'd3;
    localparam logic [2:0] K_LPAR = 3'd4;
    localparam logic [2:0] K_RPAR = 3'd5;
    localparam logic [2:0] K_END  = 3'd6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_kind = 3'd0;
    logic [15:0] in_data = 16'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_push;
    logic [15:0] out_d;
    logic [1:0]  out_op;
    logic        done;
    logic        err;

    int n_vec  = 0;
    int n_miss = 0;
    int done_cnt = 0;
    bit stall_mode = 1'b0;
    int stall_cnt = 0;
    bit held = 1'b0;
    logic [31:0] held_tok;
    logic [31:0] sb[$];

    infix_to_onp #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_push(out_push),
        .out_d(out_d), .out_op(out_op), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] tok_num(input logic [15:0] v);
        return {15'd0, 1'b1, v};
    endfunction

    function automatic logic [31:0] tok_op(input logic [1:0] c);
        return {30'd0, c};
    endfunction

    // Downstream model: either always ready, or holds each token for three cycles.
    always @(posedge clk) begin
        #1;
        if (!stall_mode) begin
            out_ready = 1'b1;
            stall_cnt = 0;
        end else if (out_valid) begin
            if (stall_cnt < 3) begin
                out_ready = 1'b0;
                stall_cnt++;
            end else begin
                out_ready = 1'b1;
                stall_cnt = 0;
            end
        end else begin
            out_ready = 1'b0;
            stall_cnt = 0;
        end
    end

    always @(negedge clk) begin
        logic [31:0] tok;
        if (rst) begin
            held = 1'b0;
        end else begin
            tok = out_push ? {15'd0, 1'b1, out_d} : {30'd0, out_op};
            if (held) check("stable", tok, held_tok);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) check("extra_tok", tok, 32'hFFFF_FFFF);
                else                check("tok", tok, sb.pop_front());
                held = 1'b0;
            end else if (out_valid) begin
                check("in_rdy_hold", {31'd0, in_ready}, 32'd0);
                held     = 1'b1;
                held_tok = tok;
            end else begin
                held = 1'b0;
            end
            if (done) done_cnt++;
        end
    end

    task automatic send(input logic [2:0] kind, input logic [15:0] data);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_kind  = kind;
        in_data  = data;
        for (int i = 0; i < 200 && !ok; i++) begin
            #2;
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) check("in_timeout", 32'd0, 32'd1);
    endtask

    task automatic num(input logic [15:0] v);
        sb.push_back(tok_num(v));
        send(K_NUM, v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        done_cnt = 0;
        rst = 1'b0;
    endtask

    task automatic finish_expr(input string tag);
        for (int i = 0; i < 300 && done_cnt == 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        check({tag, "_done"}, done_cnt, 32'd1);
        check({tag, "_sb_empty"}, sb.size(), 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    task automatic expect_err(input string tag);
        repeat (4) @(negedge clk);
        check({tag, "_err"}, {31'd0, err}, 32'd1);
        in_valid = 1'b1;
        in_kind  = K_NUM;
        in_data  = 16'h00AA;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        check({tag, "_sb_empty"}, sb.size(), 32'd0);
    endtask

    initial begin
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_push",  {31'd0, out_push},  32'd0);
        check("rst_out_d",     {16'd0, out_d},     32'd0);
        check("rst_out_op",    {30'd0, out_op},    32'd0);
        check("rst_done",      {31'd0, done},      32'd0);
        check("rst_err",       {31'd0, err},       32'd0);
        @(posedge clk);
        do_reset();

        // 2 * 3 + 4
        num(16'd2); send(K_MUL, 0); num(16'd3);
        sb.push_back(tok_op(2'b11));
        send(K_ADD, 0); num(16'd4);
        sb.push_back(tok_op(2'b10));
        send(K_END, 0);
        finish_expr("mul_add");

        // 2 + 3 * 4 (directly after done, without reset)
        done_cnt = 0;
        num(16'd2); send(K_ADD, 0); num(16'd3); send(K_MUL, 0); num(16'd4);
        sb.push_back(tok_op(2'b11));
        sb.push_back(tok_op(2'b10));
        send(K_END, 0);
        finish_expr("add_mul");

        // NEG ( 1 + 2 ) * 3
        do_reset();
        send(K_NEG, 0); send(K_LPAR, 0); num(16'd1); send(K_ADD, 0); num(16'd2);
        sb.push_back(tok_op(2'b10));
        send(K_RPAR, 0);
        sb.push_back(tok_op(2'b01));
        send(K_MUL, 0); num(16'd3);
        sb.push_back(tok_op(2'b11));
        send(K_END, 0);
        finish_expr("neg_par");

        // 2 * 3 + 4 with three stall cycles per output token
        do_reset();
        stall_mode = 1'b1;
        num(16'h1234); send(K_MUL, 0); num(16'd3);
        sb.push_back(tok_op(2'b11));
        send(K_ADD, 0); num(16'hBEEF);
        sb.push_back(tok_op(2'b10));
        send(K_END, 0);
        finish_expr("stall");
        stall_mode = 1'b0;

        // 5 )
        do_reset();
        num(16'd5); send(K_RPAR, 0);
        expect_err("rpar");

        // 5 5
        do_reset();
        num(16'd5); send(K_NUM, 16'd5);
        expect_err("two_num");

        // five ( on a four-entry stack
        do_reset();
        for (int i = 0; i < 5; i++) send(K_LPAR, 0);
        expect_err("overflow");

        // async reset after 1 + (
        do_reset();
        num(16'd1); send(K_ADD, 0); send(K_LPAR, 0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_out_push",  {31'd0, out_push},  32'd0);
        check("arst_out_d",     {16'd0, out_d},     32'd0);
        check("arst_out_op",    {30'd0, out_op},    32'd0);
        check("arst_done",      {31'd0, done},      32'd0);
        check("arst_err",       {31'd0, err},       32'd0);
        check("arst_sb_empty",  sb.size(),          32'd0);
        do_reset();
        num(16'd7); send(K_END, 0);
        finish_expr("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
